// File: rtl/mm_pkg.sv
// Shared constants and types for the 256-bit Montgomery datapath.
package mm_pkg;
    localparam int unsigned MM_W           = 256;
    localparam int unsigned MM_LAT_DEFAULT = 6;

    typedef logic [MM_W-1:0] mm_word_t;

    localparam mm_word_t MM_MOD =
        256'h73eda753299d7d483339d80809a1d80553bda402fffe5bfeffffffff00000001;
endpackage

// File: rtl/mm_acc_256_if.sv
// Issue/result/output bundle between the multiplier, the accumulate stage and its consumer.
interface mm_acc_256_if;
    import mm_pkg::*;

    logic     issue_valid;
    logic     issue_last;
    logic     issue_ready;
    mm_word_t mm_result;
    logic     out_valid;
    logic     out_ready;
    mm_word_t out_data;
    logic     err_overflow;

    modport master (
        output issue_valid, issue_last, mm_result, out_ready,
        input  issue_ready, out_valid, out_data, err_overflow
    );

    modport slave (
        input  issue_valid, issue_last, mm_result, out_ready,
        output issue_ready, out_valid, out_data, err_overflow
    );
endinterface

// File: rtl/mod_add_256.sv
// Combinational (a + b) mod M for a, b < M: one 257-bit add and a single conditional subtract.
module mod_add_256
    import mm_pkg::*;
(
    input  mm_word_t a_i,
    input  mm_word_t b_i,
    output mm_word_t sum_o
);
    logic [MM_W:0] sum;
    logic [MM_W:0] diff;

    always_comb begin
        sum   = {1'b0, a_i} + {1'b0, b_i};
        diff  = sum - {1'b0, MM_MOD};
        sum_o = (sum >= {1'b0, MM_MOD}) ? diff[MM_W-1:0] : sum[MM_W-1:0];
    end
endmodule

// File: rtl/mm_acc_256.sv
// Modular accumulate stage behind mm_256x256: tag delay line, per-group sum mod M,
// output FIFO and credit-based backpressure on group-closing issues.
module mm_acc_256
    import mm_pkg::*;
#(
    parameter int unsigned MM_LAT    = MM_LAT_DEFAULT,
    parameter int unsigned OUT_DEPTH = 4
) (
    input logic         clk,
    input logic         rst_n,
    mm_acc_256_if.slave acc_if
);
    localparam int unsigned PtrW  = (OUT_DEPTH > 1) ? $clog2(OUT_DEPTH) : 1;
    localparam int unsigned CntW  = PtrW + 1;
    localparam int unsigned InflW = PtrW + 2;

    logic [MM_LAT-1:0] vld_q, vld_d, lst_q, lst_d;
    mm_word_t          acc_q, acc_d;
    logic              open_q, open_d;
    mm_word_t          mem_q [OUT_DEPTH];
    mm_word_t          mem_d [OUT_DEPTH];
    logic [PtrW-1:0]   wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
    logic [CntW-1:0]   cnt_q, cnt_d;
    logic [InflW-1:0]  infl_q, infl_d;
    logic              err_q, err_d;

    logic              p_valid, p_last;
    mm_word_t          addend, sum;
    logic              push, pop, full, push_ok, inc, dec;
    logic [InflW:0]    occupancy;
    logic [MM_LAT:0]   vld_ext, lst_ext;

    assign p_valid = vld_q[MM_LAT-1];
    assign p_last  = lst_q[MM_LAT-1];
    assign addend  = open_q ? acc_q : '0;

    mod_add_256 u_add (
        .a_i  (addend),
        .b_i  (acc_if.mm_result),
        .sum_o(sum)
    );

    assign acc_if.out_valid    = (cnt_q != '0);
    assign acc_if.out_data     = mem_q[rd_ptr_q];
    assign acc_if.err_overflow = err_q;

    // Credits cover both queued results and closes still travelling through the multiplier.
    assign occupancy          = (InflW+1)'(cnt_q) + (InflW+1)'(infl_q);
    assign acc_if.issue_ready = occupancy < (InflW+1)'(OUT_DEPTH);

    always_comb begin
        vld_ext = {vld_q, acc_if.issue_valid};
        lst_ext = {lst_q, acc_if.issue_last};
        vld_d   = vld_ext[MM_LAT-1:0];
        lst_d   = lst_ext[MM_LAT-1:0];

        push    = p_valid & p_last;
        pop     = acc_if.out_valid & acc_if.out_ready;
        full    = (cnt_q == CntW'(OUT_DEPTH));
        push_ok = push & (~full | pop);
        inc     = acc_if.issue_valid & acc_if.issue_last;
        dec     = push;

        acc_d    = acc_q;
        open_d   = open_q;
        mem_d    = mem_q;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        cnt_d    = cnt_q;
        infl_d   = infl_q;
        err_d    = err_q | (push & full & ~pop);

        if (p_valid) begin
            if (p_last) begin
                acc_d  = '0;
                open_d = 1'b0;
            end else begin
                acc_d  = sum;
                open_d = 1'b1;
            end
        end

        if (push_ok) begin
            mem_d[wr_ptr_q] = sum;
            wr_ptr_d        = wr_ptr_q + PtrW'(1);
        end
        if (pop) begin
            rd_ptr_d = rd_ptr_q + PtrW'(1);
        end

        case ({push_ok, pop})
            2'b10:   cnt_d = cnt_q + CntW'(1);
            2'b01:   cnt_d = cnt_q - CntW'(1);
            default: cnt_d = cnt_q;
        endcase

        case ({inc, dec})
            2'b10:   infl_d = infl_q + InflW'(1);
            2'b01:   infl_d = infl_q - InflW'(1);
            default: infl_d = infl_q;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            vld_q    <= '0;
            lst_q    <= '0;
            acc_q    <= '0;
            open_q   <= 1'b0;
            mem_q    <= '{default: '0};
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            cnt_q    <= '0;
            infl_q   <= '0;
            err_q    <= 1'b0;
        end else begin
            vld_q    <= vld_d;
            lst_q    <= lst_d;
            acc_q    <= acc_d;
            open_q   <= open_d;
            mem_q    <= mem_d;
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            cnt_q    <= cnt_d;
            infl_q   <= infl_d;
            err_q    <= err_d;
        end
    end
endmodule

// File: tb/tb_mm_acc_256.sv
// Directed and random stimulus for mm_acc_256 against a group-sum / credit reference model.
module tb_mm_acc_256;
    import mm_pkg::*;

    localparam int unsigned LAT = MM_LAT_DEFAULT;
    localparam int unsigned DEP = 4;

    typedef struct {
        mm_word_t d;
        int       avail;
    } exp_t;

    logic clk   = 1'b0;
    logic rst_n = 1'b1;
    always #5 clk = ~clk;

    mm_acc_256_if acc_if ();

    mm_acc_256 #(
        .MM_LAT   (LAT),
        .OUT_DEPTH(DEP)
    ) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .acc_if(acc_if)
    );

    int       n_chk = 0;
    int       n_err = 0;
    int       cyc = 0;
    int       outstanding = 0;
    bit       chk_on = 1'b1;
    mm_word_t acc_m = '0;
    exp_t     exp_q[$];
    mm_word_t iss_data = '0;
    mm_word_t mpipe [LAT];

    function automatic mm_word_t rand256();
        mm_word_t r;
        for (int i = 0; i < 8; i++) r[i*32 +: 32] = $urandom;
        return r;
    endfunction

    function automatic mm_word_t rand_mod();
        return rand256() % MM_MOD;
    endfunction

    function automatic mm_word_t madd(input mm_word_t a, input mm_word_t b);
        logic [MM_W:0] s;
        s = ({1'b0, a} + {1'b0, b}) % {1'b0, MM_MOD};
        return s[MM_W-1:0];
    endfunction

    // Stand-in for mm_256x256: the product appears LAT cycles after issue; idle slots carry junk.
    always @(posedge clk) begin
        for (int i = LAT - 1; i > 0; i--) mpipe[i] <= mpipe[i-1];
        mpipe[0] <= acc_if.issue_valid ? iss_data : rand256();
    end
    assign acc_if.mm_result = mpipe[LAT-1];

    task automatic chk(input string tag, input mm_word_t obs, input mm_word_t exp_v);
        n_chk++;
        assert (obs === exp_v) else begin
            n_err++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp_v);
        end
    endtask

    task automatic step(input logic v, input logic l, input mm_word_t d, input logic rdy);
        logic exp_ov;
        acc_if.issue_valid = v;
        acc_if.issue_last  = l;
        acc_if.out_ready   = rdy;
        iss_data           = d;
        if (v) begin
            acc_m = madd(acc_m, d);
            if (l) begin
                exp_q.push_back('{d: acc_m, avail: cyc + LAT + 1});
                acc_m = '0;
            end
        end
        @(negedge clk);
        exp_ov = (exp_q.size() != 0) && (exp_q[0].avail <= cyc);
        if (chk_on) begin
            chk("out_valid", MM_W'(acc_if.out_valid), MM_W'(exp_ov));
            if (exp_ov) chk("out_data", acc_if.out_data, exp_q[0].d);
            chk("issue_ready", MM_W'(acc_if.issue_ready), MM_W'(outstanding < int'(DEP)));
            chk("err_overflow", MM_W'(acc_if.err_overflow), '0);
        end
        if (v && l) outstanding++;
        if (exp_ov && rdy) begin
            void'(exp_q.pop_front());
            outstanding--;
        end
        @(posedge clk);
        #1;
        cyc++;
    endtask

    task automatic idle(input int n, input logic rdy);
        for (int i = 0; i < n; i++) step(1'b0, 1'b0, rand256(), rdy);
    endtask

    task automatic do_reset();
        acc_if.issue_valid = 1'b0;
        acc_if.issue_last  = 1'b0;
        acc_if.out_ready   = 1'b0;
        rst_n              = 1'b0;
        acc_m              = '0;
        outstanding        = 0;
        exp_q.delete();
        #1;
        chk("rst_issue_ready", MM_W'(acc_if.issue_ready), MM_W'(1));
        chk("rst_out_valid", MM_W'(acc_if.out_valid), '0);
        chk("rst_out_data", acc_if.out_data, '0);
        chk("rst_err_overflow", MM_W'(acc_if.err_overflow), '0);
        repeat (2) begin
            @(posedge clk);
            cyc++;
        end
        #1;
        rst_n = 1'b1;
    endtask

    initial begin
        acc_if.issue_valid = 1'b0;
        acc_if.issue_last  = 1'b0;
        acc_if.out_ready   = 1'b0;
        #1;
        do_reset();

        // Single-element group.
        step(1'b1, 1'b1, 256'd5, 1'b1);
        idle(LAT + 3, 1'b1);

        // M-1 then 2 wraps to 1.
        step(1'b1, 1'b0, MM_MOD - 256'd1, 1'b1);
        step(1'b1, 1'b1, 256'd2, 1'b1);
        idle(LAT + 3, 1'b1);

        // Back-to-back single groups.
        for (int i = 1; i <= 4; i++) step(1'b1, 1'b1, MM_W'(i), 1'b1);
        idle(LAT + 3, 1'b1);

        // Fill the FIFO with the consumer stalled, then drain.
        for (int i = 0; i < int'(DEP); i++) step(1'b1, 1'b1, rand_mod(), 1'b0);
        idle(LAT + 4, 1'b0);
        idle(DEP + 3, 1'b1);

        // Gapped group.
        step(1'b1, 1'b0, 256'd7, 1'b1);
        idle(2, 1'b1);
        step(1'b1, 1'b1, 256'd9, 1'b1);
        idle(LAT + 3, 1'b1);

        // Reset with partial group in flight.
        for (int i = 0; i < 3; i++) step(1'b1, 1'b0, rand_mod(), 1'b1);
        do_reset();
        idle(LAT + 2, 1'b1);
        step(1'b1, 1'b1, 256'd10, 1'b1);
        idle(LAT + 3, 1'b1);

        // Random traffic, honouring issue_ready for closing elements.
        for (int i = 0; i < 400; i++) begin
            logic v, l, r;
            v = ($urandom_range(3) != 0);
            l = ($urandom_range(2) == 0) && (outstanding < int'(DEP));
            r = ($urandom_range(3) != 0);
            step(v, l, rand_mod(), r);
        end
        idle(LAT + DEP + 6, 1'b1);
        chk("drained", MM_W'(exp_q.size()), '0);

        // Protocol violation: one close too many while stalled sets the sticky error.
        chk_on = 1'b0;
        for (int i = 0; i <= int'(DEP); i++) step(1'b1, 1'b1, rand_mod(), 1'b0);
        idle(LAT + 3, 1'b0);
        chk("overflow_set", MM_W'(acc_if.err_overflow), MM_W'(1));
        chk("overflow_full", MM_W'(acc_if.out_valid), MM_W'(1));
        do_reset();
        chk_on = 1'b1;
        step(1'b1, 1'b1, 256'd3, 1'b1);
        idle(LAT + 3, 1'b1);

        $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
        $finish;
    end
endmodule
